// File: rtl/imem_pkg.sv
// Shared types and sizes for the instruction memory and its loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imem_pkg;

   localparam int IMEM_ADDR_W = 16;
   localparam int IMEM_WORDS  = 1024;

   typedef logic [31:0] instr_word_t;

   typedef enum logic [2:0] {
      IDLE,
      COLLECT,
      WRITE,
      CHECK,
      DONE
   } loader_state_t;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream input and memory write port of the instruction memory loader.
// Latency: n/a (wiring only).
// Backpressure: byte_ready_o stalls the stream; the write port has none.
interface instr_mem_loader_if #(
   parameter int ADDR_W = 16
) ();

   logic [7:0]        byte_i;
   logic              byte_valid_i;
   logic              byte_ready_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_waddr_o;
   logic [31:0]       mem_wdata_o;

   // Loader side: consumes the byte stream, drives the memory write port.
   modport master (
      input  byte_i,
      input  byte_valid_i,
      output byte_ready_o,
      output mem_we_o,
      output mem_waddr_o,
      output mem_wdata_o
   );

   // Environment side: produces the byte stream, observes the writes.
   modport slave (
      output byte_i,
      output byte_valid_i,
      input  byte_ready_o,
      input  mem_we_o,
      input  mem_waddr_o,
      input  mem_wdata_o
   );

endinterface

// File: rtl/instr_mem_loader_word_assembler.sv
// Packs pushed bytes little-endian into a 32-bit word (byte k -> bits [8k+7:8k]).
// Latency: word register holds all four bytes the cycle after the 4th push.
// Backpressure: none; word_full flags the push that completes the word.
import imem_pkg::*;

module word_assembler (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        push,
   input  logic [7:0]  byte_in,
   output instr_word_t word,
   output logic        word_full
);

   logic [1:0] cnt;

   // Combinational so the FSM can leave COLLECT on the same edge that stores byte 3.
   assign word_full = push && (cnt == 2'd3);

   // Byte slot counter and packing register; a clear drops any partial word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         word <= '0;
      end else if (clear) begin
         cnt  <= '0;
         word <= '0;
      end else if (push) begin
         word[{cnt, 3'b000} +: 8] <= byte_in;
         cnt                      <= cnt + 2'd1;
      end
   end

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a byte stream into instruction memory as consecutive 32-bit words from a base address.
// Latency: last byte accepted N -> write N+1 -> done N+2 (N+3 with LOADER_CHECKSUM_EN).
// Backpressure: byte_ready_o only in COLLECT/CHECK; optional checksum byte via LOADER_CHECKSUM_EN.
import imem_pkg::*;

module instr_mem_loader #(
   parameter int ADDR_W    = IMEM_ADDR_W,
   parameter int MAX_WORDS = IMEM_WORDS,
   parameter int CNT_W     = 11
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start_i,
   input  logic [ADDR_W-1:0]       base_addr_i,
   input  logic [CNT_W-1:0]        word_count_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    err_o,
   instr_mem_loader_if.master      bus
);

   loader_state_t     state, state_nxt;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] base_aligned;
   logic [CNT_W-1:0]  remaining;
   logic [ADDR_W-1:0] waddr_hold;
   instr_word_t       wdata_hold;
   instr_word_t       asm_word;
   logic              err;
   logic              start_acc;
   logic              accept;
   logic              word_full;
   logic              in_range;
   logic              write_ok;
   logic              ready;
   logic              is_write;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        xsum;
   logic              chk_accept;
`endif

   assign base_aligned = base_addr_i & ~ADDR_W'(3);
   assign in_range     = 32'(addr[ADDR_W-1:2]) < 32'(MAX_WORDS);
   assign is_write     = (state == WRITE);

   word_assembler u_asm (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (start_acc),
      .push      (accept),
      .byte_in   (bus.byte_i),
      .word      (asm_word),
      .word_full (word_full)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state and handshake decode.
   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      start_acc = 1'b0;
      accept    = 1'b0;
      write_ok  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      chk_accept = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (start_i) begin
               start_acc = 1'b1;
               state_nxt = (word_count_i == '0) ? DONE : COLLECT;
            end
         end
         COLLECT: begin
            ready  = 1'b1;
            accept = bus.byte_valid_i;
            if (word_full) state_nxt = WRITE;
         end
         WRITE: begin
            write_ok = in_range;
            if (remaining == CNT_W'(1)) begin
`ifdef LOADER_CHECKSUM_EN
               state_nxt = CHECK;
`else
               state_nxt = DONE;
`endif
            end else begin
               state_nxt = COLLECT;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         CHECK: begin
            ready      = 1'b1;
            chk_accept = bus.byte_valid_i;
            if (bus.byte_valid_i) state_nxt = DONE;
         end
`endif
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Address, remaining count, sticky error and last-written hold registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr       <= '0;
         remaining  <= '0;
         err        <= 1'b0;
         waddr_hold <= '0;
         wdata_hold <= '0;
      end else begin
         if (start_acc) begin
            addr      <= base_aligned;
            remaining <= word_count_i;
            err       <= 1'b0;
         end else if (is_write) begin
            // Out-of-range words are still consumed so the stream stays in step.
            addr      <= addr + ADDR_W'(4);
            remaining <= remaining - CNT_W'(1);
            if (!in_range) err <= 1'b1;
         end
`ifdef LOADER_CHECKSUM_EN
         if (chk_accept && (bus.byte_i != xsum)) err <= 1'b1;
`endif
         if (write_ok) begin
            waddr_hold <= addr;
            wdata_hold <= asm_word;
         end
      end
   end

`ifdef LOADER_CHECKSUM_EN
   // Running XOR of every accepted data byte of the current load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         xsum <= '0;
      else if (start_acc) xsum <= '0;
      else if (accept)    xsum <= xsum ^ bus.byte_i;
   end
`endif

   // Write port shows the live word only on an issued write, otherwise the last one.
   assign bus.mem_we_o    = write_ok;
   assign bus.mem_waddr_o = write_ok ? addr : waddr_hold;
   assign bus.mem_wdata_o = write_ok ? asm_word : wdata_hold;
   assign bus.byte_ready_o = ready;

   // busy rises the cycle after start and covers DONE, so a zero-word load is busy one cycle.
   assign busy_o = (state != IDLE);
   assign done_o = (state == DONE);
   assign err_o  = err;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: scoreboard of expected writes plus done/err/latency checks.
// Latency: expects done 2 cycles after the last data byte (3 with LOADER_CHECKSUM_EN).
// Backpressure: stream driver holds byte_valid_i until byte_ready_o is seen.
`timescale 1ns/1ps
module tb_instr_mem_loader;
   import imem_pkg::*;

   localparam int ADDR_W    = 16;
   localparam int CNT_W     = 11;
   localparam int MAX_WORDS = 1024;
`ifdef LOADER_CHECKSUM_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start_i = 1'b0;
   logic [ADDR_W-1:0] base_addr_i = '0;
   logic [CNT_W-1:0]  word_count_i = '0;
   logic              busy_o, done_o, err_o;

   instr_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

   instr_mem_loader #(
      .ADDR_W    (ADDR_W),
      .MAX_WORDS (MAX_WORDS),
      .CNT_W     (CNT_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (start_i),
      .base_addr_i  (base_addr_i),
      .word_count_i (word_count_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .err_o        (err_o),
      .bus          (bus.master)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard entries: {byte address, data word}.
   logic [47:0] exp_q[$];

   // Every issued write must match the oldest expected write.
   always @(negedge clk) begin
      if (bus.mem_we_o === 1'b1) begin
         chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) chk("write", {16'h0, bus.mem_waddr_o, bus.mem_wdata_o}, {16'h0, exp_q.pop_front()});
      end
   end

   int busy_cnt = 0;
   always @(negedge clk) if (busy_o === 1'b1) busy_cnt++;

   // Bench-side model of the load in progress.
   logic [7:0]        xsum;
   logic [31:0]       cur_word;
   logic [ADDR_W-1:0] cur_addr;
   int                byte_idx;
   int                start_cyc, acc_cyc, last_data_acc;

   task automatic do_start(input logic [ADDR_W-1:0] base, input int n);
      @(posedge clk); #1;
      start_i      = 1'b1;
      base_addr_i  = base;
      word_count_i = n[CNT_W-1:0];
      busy_cnt     = 0;
      xsum         = 8'h00;
      cur_word     = 32'h0;
      byte_idx     = 0;
      cur_addr     = {base[ADDR_W-1:2], 2'b00};
      @(negedge clk);
      start_cyc = cyc;
      @(posedge clk); #1;
      start_i = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit ok;
      ok = 1'b0;
      bus.byte_i       = b;
      bus.byte_valid_i = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (bus.byte_ready_o === 1'b1) ok = 1'b1;
      end
      acc_cyc = cyc;
      chk("byte_accepted", 64'(ok), 64'd1);
      @(posedge clk); #1;
      bus.byte_valid_i = 1'b0;
   endtask

   task automatic send_data(input logic [7:0] b);
      send_byte(b);
      last_data_acc = acc_cyc;
      xsum = xsum ^ b;
      cur_word[byte_idx*8 +: 8] = b;
      byte_idx++;
      if (byte_idx == 4) begin
         if (int'(cur_addr[ADDR_W-1:2]) < MAX_WORDS) exp_q.push_back({cur_addr, cur_word});
         cur_addr = cur_addr + 16'd4;
         cur_word = 32'h0;
         byte_idx = 0;
      end
   endtask

   task automatic finish_load(input string tag, input bit bad_chk, input bit exp_err);
      bit ok;
`ifdef LOADER_CHECKSUM_EN
      send_byte(xsum ^ {7'b0, bad_chk});
`endif
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (done_o === 1'b1) ok = 1'b1;
      end
      chk({tag, "_done_seen"}, 64'(ok), 64'd1);
      chk({tag, "_done_latency"}, 64'(cyc - last_data_acc), 64'(LAT));
      chk({tag, "_err"}, 64'(err_o), 64'(exp_err));
      chk({tag, "_writes_drained"}, 64'(exp_q.size()), 64'd0);
      @(negedge clk);
      chk({tag, "_done_pulse"}, 64'(done_o), 64'd0);
      chk({tag, "_busy_clear"}, 64'(busy_o), 64'd0);
   endtask

   initial begin
      bus.byte_i       = 8'h00;
      bus.byte_valid_i = 1'b0;
      #2;
      chk("reset_outputs", {58'h0, bus.byte_ready_o, bus.mem_we_o, busy_o, done_o, err_o, 1'b0}, 64'h0);
      chk("reset_wport", {16'h0, bus.mem_waddr_o, bus.mem_wdata_o}, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Two words from address 0.
      do_start(16'h0000, 2);
      send_data(8'h20); send_data(8'h00); send_data(8'h00); send_data(8'h00);
      send_data(8'h21); send_data(8'h00); send_data(8'h00); send_data(8'h00);
      finish_load("two_words", 1'b0, 1'b0);

      // Unaligned base is forced down to a word boundary.
      do_start(16'h0013, 1);
      send_data(8'hAA); send_data(8'hBB); send_data(8'hCC); send_data(8'hDD);
      finish_load("unaligned", 1'b0, 1'b0);

      // Zero-word load: done the cycle after start, busy for exactly one cycle, no write.
      do_start(16'h0040, 0);
      @(negedge clk);
      chk("count0_done_cycle", 64'(done_o === 1'b1 && cyc == start_cyc + 1), 64'd1);
      chk("count0_err", 64'(err_o), 64'd0);
      repeat (4) @(negedge clk);
      chk("count0_busy_cycles", 64'(busy_cnt), 64'd1);

      // Word 1023 is written, word 1024 is dropped and flagged.
      do_start(16'h0FFC, 2);
      send_data(8'h11); send_data(8'h22); send_data(8'h33); send_data(8'h44);
      send_data(8'h55); send_data(8'h66); send_data(8'h77); send_data(8'h88);
      finish_load("overflow", 1'b0, 1'b1);

      // Next start clears the sticky error.
      do_start(16'h0104, 1);
      send_data(8'h01); send_data(8'h23); send_data(8'h45); send_data(8'h67);
      finish_load("err_cleared", 1'b0, 1'b0);

      // Reset in the middle of a word: everything drops at once and nothing is written.
      do_start(16'h0100, 1);
      send_data(8'h5A); send_data(8'hA5);
      rst_n = 1'b0;
      #1;
      chk("midreset_outputs", {58'h0, bus.byte_ready_o, bus.mem_we_o, busy_o, done_o, err_o, 1'b0}, 64'h0);
      chk("midreset_wport", {16'h0, bus.mem_waddr_o, bus.mem_wdata_o}, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      do_start(16'h0200, 1);
      send_data(8'h11); send_data(8'h22); send_data(8'h33); send_data(8'h44);
      finish_load("after_reset", 1'b0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
      // Checksum 0F matches 01^02^04^08; 0E does not.
      do_start(16'h0300, 1);
      send_data(8'h01); send_data(8'h02); send_data(8'h04); send_data(8'h08);
      finish_load("chk_good", 1'b0, 1'b0);
      do_start(16'h0300, 1);
      send_data(8'h01); send_data(8'h02); send_data(8'h04); send_data(8'h08);
      finish_load("chk_bad", 1'b1, 1'b1);
`endif

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
